ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction fetch front end for the 5-stage pipelined CPU. It owns the fetch PC, issues word requests to a multi-cycle, in-order instruction memory, and buffers returned instructions in a small FIFO. It presents `{inst, pc4}` to the IF/ID register through a valid/ready handshake, where ready is the inverse of the load-use stall. A branch or jump redirect from MEM flushes the queue and silently discards every response still in flight for the wrong path.

## Interface
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2; also the cap on occupancy plus outstanding requests.
- `RESET_PC`, 32'h0000_0000 — fetch PC after reset.

- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `redirect`  in  1  — taken branch or jump (pcsrc | jump) from MEM.
- `redirect_pc`  in  32  — new fetch address (branch or jump target).
- `imem_req_valid`  out  1  — request valid.
- `imem_req_ready`  in  1  — memory accepts the request.
- `imem_req_addr`  out  32  — word-aligned byte address (the fetch PC).
- `imem_rsp_valid`  in  1  — response valid; always accepted, responses return in order.
- `imem_rsp_data`  in  32  — instruction word.
- `inst_valid`  out  1  — instruction available to IF/ID.
- `inst_ready`  in  1  — IF/ID accepts; driven as `~stall`.
- `inst`  out  32  — instruction.
- `inst_pc4`  out  32  — address of `inst` + 4.

## Operation
- **State:**
  - `fetch_pc` (32): next address to request.
  - `resp_pc` (32): address of the next response to arrive.
  - `count`: FIFO occupancy.
  - `outstanding`: requests accepted but not yet responded to.
  - `drop_cnt`: responses still to discard.
  - Counter width is `$clog2(DEPTH+1)`.
- **Issue:**
  - `imem_req_valid = rst_n & ~redirect & (count + outstanding < DEPTH)`.
  - `imem_req_addr = fetch_pc`.
  - On handshake: `fetch_pc += 4`, `outstanding++`.
- **Response:**
  - Every response decrements `outstanding`.
  - If `drop_cnt != 0`: decrement `drop_cnt` and discard the data.
  - Otherwise push `{imem_rsp_data, resp_pc+4}` and set `resp_pc += 4`.
  - The credit rule above guarantees the push never overflows.
- **Pop:** on `inst_valid & inst_ready`, advance the read pointer and decrement `count`.
- **Redirect** (priority over everything else in that cycle):
  - `fetch_pc <= redirect_pc`, `resp_pc <= redirect_pc`.
  - FIFO cleared (`count <= 0`, pointers to 0); no pop is counted.
  - `drop_cnt <= outstanding - imem_rsp_valid`; any response arriving in the redirect cycle is discarded.
  - `outstanding` decrements normally.
  - No request is issued in the redirect cycle.
- **Simultaneous push and pop:** `count` unchanged.
- **Pointer arithmetic:** pointers wrap modulo `DEPTH`; address arithmetic wraps modulo 2^32.
- **`redirect_pc`:** bits [1:0] are ignored (forced to 0).
- **Reset:** effective on any edge with `rst_n=0`, including mid-burst.
  - `fetch_pc = resp_pc = RESET_PC`; all counters 0.
  - `imem_req_valid = 0`, `inst_valid = 0`.
  - `inst` and `inst_pc4` read the cleared FIFO head: 0.
  - Responses arriving after reset for pre-reset requests are the memory's responsibility; the memory must also be reset.

## Timing
- A request accepted at cycle t with memory latency L returns at t+L. The instruction is:
  - visible on `inst` at t+L+1 without bypass;
  - visible at t+L with bypass (when the queue is empty).
- Sustained 1 instruction/cycle requires a pipelined memory and `DEPTH ≥ L+1` (L+2 without bypass).
- Redirect asserted at cycle r:
  - The first request to `redirect_pc` is issued at r+1.
  - `inst_valid` is 0 from r+1 until the first new-path response arrives.
- `inst_valid`, `inst`, and `inst_pc4` are registered (FIFO head) except on the bypass path.
- Holding: `inst_ready=0` holds `inst` and `inst_pc4` stable while `inst_valid=1`.

## Configuration
- `IFQ_BYPASS_EN` defined:
  - When `count==0`, the response is not dropped, and there is no redirect, the response drives `inst`/`inst_pc4`/`inst_valid` combinationally.
  - If `inst_ready=1` in that cycle, it is not written into the FIFO.
- Undefined:
  - Outputs come only from the FIFO head.
  - This adds one cycle of latency; no combinational path from the `imem_rsp_*` ports to the `inst*` outputs.

## Test plan
- **Reset then free-run:** `RESET_PC=0`, L=1, `inst_ready=1`.
  - Required: requests 0,4,8,… on consecutive cycles.
  - Required: `inst_pc4` sequence 4,8,12,… with no gaps after the first.
- **Backpressure:** hold `inst_ready=0` for 10 cycles with `DEPTH=4`.
  - Required: `count + outstanding` never exceeds 4; requests stop.
  - Required: on release, instructions appear in order with no loss or duplication.
- **Redirect with 2 outstanding:** assert `redirect`, `redirect_pc=0x40`.
  - Required: both old responses dropped.
  - Required: next `inst_pc4` = 0x44 and next request address = 0x40 at r+1.
- **Redirect coincident events:** redirect in the same cycle as `imem_rsp_valid=1` and `inst_ready=1`.
  - Required: that response is discarded; `drop_cnt = outstanding-1`.
  - Required: the queue is empty afterward.
- **Reset mid-stream:** drive `rst_n=0` for one cycle with a full queue.
  - Required: all outputs 0 the next cycle; refetch starts at `RESET_PC`.
- **Bypass check:** with the queue empty and one response arriving.
  - Required: `inst_valid` asserts in the same cycle with `IFQ_BYPASS_EN`, and one cycle later without it.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue - instruction fetch front end.
//
// Owns the fetch PC, issues word requests to an in-order, multi-cycle
// instruction memory and buffers returned words in a DEPTH-entry FIFO.
// The IF/ID register takes {inst, inst_pc4} through a valid/ready handshake.
// A redirect from MEM flushes the queue. Every response still in flight for
// the wrong path is counted and discarded when it arrives.
//
// Optional feature: define IFQ_BYPASS_EN to let a response go straight to
// the inst* outputs when the queue is empty. This saves one cycle of latency
// but adds a combinational path from imem_rsp_* to inst*.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2). Also the cap on
//             occupancy + outstanding requests.
//   RESET_PC  fetch address after reset.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   redirect, redirect_pc      taken branch/jump and its target
//   imem_req_valid/ready/addr  request channel (word-aligned byte address)
//   imem_rsp_valid/data        response channel (always accepted, in order)
//   inst_valid/ready           handshake to IF/ID (ready = ~stall)
//   inst, inst_pc4             instruction and its address + 4
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  // Control state (reset)
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // FIFO storage: {instruction, pc+4}. Data only, so it is not reset.
  // An empty queue presents zeros on the outputs instead.
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];

  logic [CW:0]   inflight;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_take;
  logic          fifo_nonempty;
  logic          push;
  logic          pop_fifo;
  logic [31:0]   rsp_pc4;
  logic [63:0]   head;

  // Credit: never request more than the FIFO can absorb, so a push cannot
  // overflow even while the consumer is stalled.
  assign inflight       = {1'b0, count_q} + {1'b0, out_q};
  assign credit_ok      = inflight < DEPTH_C;
  assign imem_req_valid = rst_n & ~redirect & credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  always_comb begin
    // A response is useful only if nothing is left to drop and no redirect
    // is killing it in this very cycle.
    rsp_take      = imem_rsp_valid & (drop_cnt_q == '0) & ~redirect;
    fifo_nonempty = (count_q != '0);
    rsp_pc4       = resp_pc_q + 32'd4;
    head          = mem_q[rd_ptr_q];

    inst_valid = fifo_nonempty;
    inst       = fifo_nonempty ? head[63:32] : 32'd0;
    inst_pc4   = fifo_nonempty ? head[31:0]  : 32'd0;
    push       = rsp_take;
`ifdef IFQ_BYPASS_EN
    // Empty queue: forward the response directly. If it is consumed in
    // the same cycle, it never enters the FIFO.
    if (rsp_take && !fifo_nonempty) begin
      inst_valid = 1'b1;
      inst       = imem_rsp_data;
      inst_pc4   = rsp_pc4;
      push       = ~inst_ready;
    end
`endif
    pop_fifo = fifo_nonempty & inst_ready & ~redirect;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    out_d      = out_q - CW'(imem_rsp_valid) + CW'(req_fire);
    drop_cnt_d = drop_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;

    if (redirect) begin
      // Everything still outstanding belongs to the wrong path, except a
      // response landing right now, which is simply not taken.
      fetch_pc_d = redirect_pc & ~32'h3;
      resp_pc_d  = redirect_pc & ~32'h3;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (imem_rsp_valid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
      if (rsp_take) resp_pc_d = rsp_pc4;
      if (push) begin
        mem_d[wr_ptr_q] = {imem_rsp_data, rsp_pc4};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_fifo) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop_fifo);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      out_q      <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      out_q      <= out_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: table-driven per-cycle vectors plus a
// hand-written redirect/bypass sequence against a pipelined memory model.
module tb_ifetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc4;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc4       (inst_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc4;
    logic        chk0;   // expect inst/inst_pc4 == 0 while invalid
  } vec_t;

  vec_t        tbl[$];
  int          nvec;
  int          nerr;
  int          lat;
  logic        pv [4];
  logic [31:0] pa [4];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic erv, input logic [31:0] ea,
                              input logic eiv, input logic [31:0] ep, input logic c0);
    vec_t v;
    v.rst_n = r; v.redir = rd; v.rpc = rpc; v.rdy = rdy; v.e_rv = erv;
    v.e_addr = ea; v.e_iv = eiv; v.e_pc4 = ep; v.chk0 = c0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: memory samples the request, then presents the response
  // that has aged 'lat' cycles. Reset clears the memory pipeline too.
  task automatic cycle();
    logic        f;
    logic [31:0] a;
    f = imem_req_valid & imem_req_ready;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    for (int k = 3; k > 0; k--) begin
      pv[k] = pv[k-1];
      pa[k] = pa[k-1];
    end
    pv[0] = f;
    pa[0] = a;
    if (!rst_n) for (int k = 0; k < 4; k++) pv[k] = 1'b0;
    imem_rsp_valid = pv[lat-1];
    imem_rsp_data  = pv[lat-1] ? memf(pa[lat-1]) : 32'h0;
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst_n       = v.rst_n;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    inst_ready  = v.rdy;
    #1;
    chk({tag, " req_valid"},  32'(imem_req_valid), 32'(v.e_rv));
    chk({tag, " req_addr"},   imem_req_addr, v.e_addr);
    chk({tag, " inst_valid"}, 32'(inst_valid), 32'(v.e_iv));
    if (v.e_iv) begin
      chk({tag, " inst_pc4"}, inst_pc4, v.e_pc4);
      chk({tag, " inst"},     inst, memf(v.e_pc4 - 32'd4));
    end else if (v.chk0) begin
      chk({tag, " inst_pc4"}, inst_pc4, 32'h0);
      chk({tag, " inst"},     inst, 32'h0);
    end
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    nvec = 0; nerr = 0; lat = 1;
    for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pa[k] = 32'h0; end
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    do_reset();

`ifndef IFQ_BYPASS_EN
    // Free run, L=1.
    tbl.push_back(mk(1,0,0,1, 1,32'h00, 0,0,1));
    tbl.push_back(mk(1,0,0,1, 1,32'h04, 0,0,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h08, 1,32'h04,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h0C, 1,32'h08,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h10, 1,32'h0C,0));
    // Backpressure for 10 cycles: queue fills, requests stop at credit 4.
    tbl.push_back(mk(1,0,0,0, 1,32'h14, 1,32'h10,0));
    tbl.push_back(mk(1,0,0,0, 1,32'h18, 1,32'h10,0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1,0,0,0, 0,32'h1C, 1,32'h10,0));
    // Release: in order, no loss, no duplication.
    tbl.push_back(mk(1,0,0,1, 0,32'h1C, 1,32'h10,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h1C, 1,32'h14,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h20, 1,32'h18,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h24, 1,32'h1C,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h28, 1,32'h20,0));
    // Redirect coincident with a response and inst_ready; low bits ignored.
    tbl.push_back(mk(1,1,32'h43,1, 0,32'h2C, 1,32'h24,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h40, 0,0,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h44, 0,0,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h48, 1,32'h44,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h4C, 1,32'h48,0));
    // Fill the queue, then reset mid-stream.
    tbl.push_back(mk(1,0,0,0, 1,32'h50, 1,32'h4C,0));
    tbl.push_back(mk(1,0,0,0, 1,32'h54, 1,32'h4C,0));
    tbl.push_back(mk(1,0,0,0, 0,32'h58, 1,32'h4C,0));
    tbl.push_back(mk(1,0,0,0, 0,32'h58, 1,32'h4C,0));
    tbl.push_back(mk(0,0,0,1, 0,32'h58, 1,32'h4C,0));
    tbl.push_back(mk(0,0,0,1, 0,32'h00, 0,0,1));
    tbl.push_back(mk(1,0,0,1, 1,32'h00, 0,0,1));
    tbl.push_back(mk(1,0,0,1, 1,32'h04, 0,0,0));
    tbl.push_back(mk(1,0,0,1, 1,32'h08, 1,32'h04,0));
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));
`endif

    // Redirect with two requests outstanding, memory latency 3.
    do_reset();
    lat = 3;
    apply(mk(1,0,0,1, 1,32'h00, 0,0,0), "rd c0");
    apply(mk(1,0,0,1, 1,32'h04, 0,0,0), "rd c1");
    apply(mk(1,1,32'h40,1, 0,32'h08, 0,0,0), "rd c2");
    apply(mk(1,0,0,1, 1,32'h40, 0,0,0), "rd c3");
    apply(mk(1,0,0,1, 1,32'h44, 0,0,0), "rd c4");
    apply(mk(1,0,0,1, 1,32'h48, 0,0,0), "rd c5");
    // First new-path response: same cycle with bypass, one later without.
    apply(mk(1,0,0,1, 1,32'h4C, BYP,32'h44,0), "rd c6");
    apply(mk(1,0,0,1, BYP,32'h50, 1, BYP ? 32'h48 : 32'h44,0), "rd c7");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
